// File: rtl/serial_frame_pkg.sv
// Shared types and default parameters for the serial frame receiver.
// Holds the FSM state encoding and the frame-count width used by the top level.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    localparam int          DEF_DATA_W   = 8;
    localparam int          DEF_SYNC_W   = 4;
    localparam logic [3:0]  DEF_SYNC_PAT = 4'b1101;
    localparam int          FRAME_CNT_W  = 8;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift register, newest bit enters at the LSB.
// One-cycle update per enabled edge; reset and clear are synchronous and win over enable.
module sipo_shift_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_din,
    output logic [W-1:0] o_dat
);

    logic [W-1:0] r_sh;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_sh <= '0;
        end else if (i_en) begin
            r_sh <= {r_sh[W-2:0], i_din};
        end
    end

    assign o_dat = r_sh;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: sliding sync hunt, MSB-first data word, even-parity check, good-frame count.
// Outputs register on the edge sampling the parity bit; no backpressure, En=0 simply freezes progress.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                SYNC_W   = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(DEF_SYNC_PAT)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Din,
    input  logic                   En,
    output logic [DATA_W-1:0]      Dout,
    output logic                   Valid,
    output logic                   ParErr,
    output logic                   Busy,
    output logic [FRAME_CNT_W-1:0] FrameCnt
);

    localparam int FILL_W = $clog2(SYNC_W + 1);
    localparam int CNT_W  = $clog2(DATA_W + 1);

    localparam logic [FILL_W-1:0]      FILL_MAX = FILL_W'(SYNC_W);
    localparam logic [FILL_W-1:0]      FILL_ONE = FILL_W'(1);
    localparam logic [CNT_W-1:0]       BIT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]       BIT_ONE  = CNT_W'(1);
    localparam logic [FRAME_CNT_W-1:0] FCNT_ONE = FRAME_CNT_W'(1);

    // The bit shifted out of the window's MSB is ignored by masking it off.
    localparam logic [SYNC_W:0] HIT_MASK = {1'b0, {SYNC_W{1'b1}}};
    localparam logic [SYNC_W:0] HIT_PAT  = {1'b0, SYNC_PAT};

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [FILL_W-1:0]        r_fill;
    logic [FILL_W-1:0]        w_fill_nxt;
    logic [CNT_W-1:0]         r_bit_cnt;
    logic [DATA_W-1:0]        r_dout;
    logic                     r_valid;
    logic                     r_par_err;
    logic [FRAME_CNT_W-1:0]   r_frame_cnt;

    logic                     w_hunt_step;
    logic                     w_data_step;
    logic                     w_par_step;
    logic                     w_sync_hit;
    logic                     w_data_last;
    logic                     w_par_err;
    logic                     w_busy;
    logic [SYNC_W-1:0]        w_win;
    logic [DATA_W-1:0]        w_dat;

    assign w_hunt_step = En && (r_state == ST_HUNT);
    assign w_data_step = En && (r_state == ST_DATA);
    assign w_par_step  = En && (r_state == ST_PAR);

    sipo_shift_reg #(.W(SYNC_W)) u_sync_win (
        .i_clk (Clk),
        .i_rst (Reset),
        .i_clr (w_par_step),
        .i_en  (w_hunt_step),
        .i_din (Din),
        .o_dat (w_win)
    );

    sipo_shift_reg #(.W(DATA_W)) u_data_sh (
        .i_clk (Clk),
        .i_rst (Reset),
        .i_clr (1'b0),
        .i_en  (w_data_step),
        .i_din (Din),
        .o_dat (w_dat)
    );

    assign w_fill_nxt  = (r_fill == FILL_MAX) ? r_fill : (r_fill + FILL_ONE);
    assign w_sync_hit  = w_hunt_step && (w_fill_nxt == FILL_MAX) &&
                         (({w_win, Din} & HIT_MASK) == HIT_PAT);
    assign w_data_last = w_data_step && (r_bit_cnt == BIT_LAST);
    assign w_par_err   = ^{w_dat, Din};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HUNT: if (w_sync_hit)  w_state_nxt = ST_DATA;
            ST_DATA: if (w_data_last) w_state_nxt = ST_PAR;
            ST_PAR:  if (En)          w_state_nxt = ST_HUNT;
            default:                  w_state_nxt = ST_HUNT;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        if ((r_state == ST_DATA) || (r_state == ST_PAR)) begin
            w_busy = 1'b1;
        end
    end

    // Fill restarts after every frame so sync never borrows bits from old data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fill    <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (w_par_step) begin
                r_fill <= '0;
            end else if (w_hunt_step) begin
                r_fill <= w_fill_nxt;
            end

            if (w_sync_hit) begin
                r_bit_cnt <= '0;
            end else if (w_data_step) begin
                r_bit_cnt <= r_bit_cnt + BIT_ONE;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_dout      <= '0;
            r_valid     <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_valid   <= w_par_step;
            r_par_err <= w_par_step && w_par_err;
            if (w_par_step) begin
                r_dout <= w_dat;
                if (!w_par_err) begin
                    r_frame_cnt <= r_frame_cnt + FCNT_ONE;
                end
            end
        end
    end

    assign Dout     = r_dout;
    assign Valid    = r_valid;
    assign ParErr   = r_par_err;
    assign Busy     = w_busy;
    assign FrameCnt = r_frame_cnt;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: good/bad parity, overlapping sync, enable gaps,
// mid-frame reset and frame-counter wrap, all against hand-computed values.
module tb_serial_frame_rx;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Din;
    logic       En;
    logic [7:0] Dout;
    logic       Valid;
    logic       ParErr;
    logic       Busy;
    logic [7:0] FrameCnt;

    int total   = 0;
    int bad     = 0;
    int busy_hi = 0;
    int vld_cnt = 0;

    serial_frame_rx dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Din      (Din),
        .En       (En),
        .Dout     (Dout),
        .Valid    (Valid),
        .ParErr   (ParErr),
        .Busy     (Busy),
        .FrameCnt (FrameCnt)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sample just after the active edge and tally Busy/Valid cycles.
    task automatic tick();
        @(posedge Clk);
        #1;
        if (Busy)  busy_hi++;
        if (Valid) vld_cnt++;
    endtask

    task automatic put(input logic b);
        @(negedge Clk);
        Din = b;
        En  = 1'b1;
        tick();
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Din = 1'b1;
            En  = 1'b0;
            tick();
        end
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            put(v[i]);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p);
        send_bits(16'hD, 4);
        send_bits({8'h00, d}, 8);
        put(p);
    endtask

    // Reset is driven with En=1 so it must override a live bit.
    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        En    = 1'b1;
        Din   = 1'b1;
        tick();
        Reset = 1'b0;
        busy_hi = 0;
        vld_cnt = 0;
    endtask

    initial begin
        Reset = 1'b1;
        En    = 1'b0;
        Din   = 1'b0;
        repeat (2) @(posedge Clk);

        // Good frame
        do_reset();
        chk("rst_dout",   32'(Dout),     32'h0);
        chk("rst_valid",  32'(Valid),    32'h0);
        chk("rst_parerr", 32'(ParErr),   32'h0);
        chk("rst_busy",   32'(Busy),     32'h0);
        chk("rst_cnt",    32'(FrameCnt), 32'h0);
        send_bits(16'b110, 3);
        chk("good_pre_sync_busy", 32'(Busy), 32'h0);
        put(1'b1);
        chk("good_sync_busy", 32'(Busy), 32'h1);
        send_bits(16'hA5, 8);
        chk("good_pre_par_valid", 32'(Valid), 32'h0);
        put(1'b0);
        chk("good_valid",  32'(Valid),    32'h1);
        chk("good_dout",   32'(Dout),     32'hA5);
        chk("good_parerr", 32'(ParErr),   32'h0);
        chk("good_cnt",    32'(FrameCnt), 32'h1);
        chk("good_busy_fall", 32'(Busy),  32'h0);
        chk("good_busy_cycles", 32'(busy_hi), 32'd9);
        put(1'b0);
        chk("good_valid_drop", 32'(Valid), 32'h0);
        chk("good_dout_hold",  32'(Dout),  32'hA5);

        // Parity error
        do_reset();
        send_frame(8'hA5, 1'b1);
        chk("perr_valid",  32'(Valid),    32'h1);
        chk("perr_parerr", 32'(ParErr),   32'h1);
        chk("perr_dout",   32'(Dout),     32'hA5);
        chk("perr_cnt",    32'(FrameCnt), 32'h0);
        put(1'b0);
        chk("perr_parerr_drop", 32'(ParErr), 32'h0);

        // Overlapping sync prefix, then back-to-back frames
        do_reset();
        send_bits(16'b1110, 4);
        chk("ovl_no_early_match", 32'(Busy), 32'h0);
        put(1'b1);
        chk("ovl_match_5th", 32'(Busy), 32'h1);
        send_bits(16'h3C, 8);
        put(1'b0);
        chk("ovl_dout",  32'(Dout),     32'h3C);
        chk("ovl_valid", 32'(Valid),    32'h1);
        chk("ovl_cnt",   32'(FrameCnt), 32'h1);
        put(1'b1);
        chk("b2b_valid_gap", 32'(Valid), 32'h0);
        send_bits(16'b101, 3);
        chk("b2b_sync_busy", 32'(Busy), 32'h1);
        send_bits(16'h5A, 8);
        put(1'b0);
        chk("b2b_dout",   32'(Dout),     32'h5A);
        chk("b2b_cnt",    32'(FrameCnt), 32'h2);
        chk("b2b_pulses", 32'(vld_cnt),  32'd2);

        // Enable gaps mid-sync, mid-data and before parity
        do_reset();
        put(1'b1);
        put(1'b1);
        gap(2);
        put(1'b0);
        chk("gap_sync_busy", 32'(Busy), 32'h0);
        put(1'b1);
        chk("gap_sync_hit", 32'(Busy), 32'h1);
        send_bits(16'hC, 4);
        gap(3);
        chk("gap_data_busy",  32'(Busy),  32'h1);
        chk("gap_data_valid", 32'(Valid), 32'h0);
        send_bits(16'h3, 4);
        gap(1);
        chk("gap_prepar_valid", 32'(Valid), 32'h0);
        chk("gap_prepar_busy",  32'(Busy),  32'h1);
        put(1'b0);
        chk("gap_valid",  32'(Valid),    32'h1);
        chk("gap_dout",   32'(Dout),     32'hC3);
        chk("gap_parerr", 32'(ParErr),   32'h0);
        chk("gap_cnt",    32'(FrameCnt), 32'h1);
        gap(1);
        chk("gap_valid_drop_en0", 32'(Valid), 32'h0);
        chk("gap_dout_hold",      32'(Dout),  32'hC3);
        chk("gap_busy_cycles", 32'(busy_hi), 32'd13);

        // Reset in the middle of a frame
        do_reset();
        send_frame(8'hA5, 1'b0);
        chk("mrst_pre_cnt", 32'(FrameCnt), 32'h1);
        send_bits(16'hD, 4);
        send_bits(16'hA, 4);
        do_reset();
        chk("mrst_dout",   32'(Dout),     32'h0);
        chk("mrst_cnt",    32'(FrameCnt), 32'h0);
        chk("mrst_busy",   32'(Busy),     32'h0);
        chk("mrst_valid",  32'(Valid),    32'h0);
        chk("mrst_parerr", 32'(ParErr),   32'h0);
        send_bits(16'b101, 3);
        send_bits(16'b110, 3);
        chk("mrst_no_stale_match", 32'(Busy), 32'h0);
        put(1'b1);
        chk("mrst_sync_hit", 32'(Busy), 32'h1);
        send_bits(16'h96, 8);
        put(1'b0);
        chk("mrst_dout_new", 32'(Dout),     32'h96);
        chk("mrst_cnt_new",  32'(FrameCnt), 32'h1);
        chk("mrst_pulses",   32'(vld_cnt),  32'd1);

        // Frame counter wrap
        do_reset();
        for (int f = 1; f <= 256; f++) begin
            send_frame(8'h00, 1'b0);
            if (f == 255) begin
                chk("wrap_255", 32'(FrameCnt), 32'd255);
            end
        end
        chk("wrap_0",      32'(FrameCnt), 32'd0);
        chk("wrap_pulses", 32'(vld_cnt),  32'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
